// File: rtl/crc_frame_rx.sv
// Bit-serial 40-bit frame receiver (24-bit payload + CRC-16-CCITT, MSB first).
// Checks the CRC residue and presents the payload on a valid/ready output register.
module crc_frame_rx #(
  parameter int GAP_MAX = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] payload_out,
  output logic        crc_ok,
  output logic        err_abort,
  output logic        err_overrun,
  output logic        dbg_state
);

  // Handshake: a frame transfers on a rising edge where out_valid && out_ready;
  // out_valid never drops without a transfer, and the held frame is stable until then.

  localparam int GW = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);
  localparam logic [GW-1:0] GAP_LIM = GW'(GAP_MAX);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [5:0]    cnt_q;
  logic [15:0]   crc_q;
  logic [15:0]   crc_d;
  logic [23:0]   shreg_q;
  logic [GW-1:0] gap_q;

  logic start, take, last, gap_hit, abort;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RECV;
      RECV: begin
        if (start)        state_d = RECV;
        else if (last)    state_d = IDLE;
        else if (gap_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A sof bit always restarts a frame; in RECV it also discards the partial one.
  always_comb begin
    start   = 1'b0;
    take    = 1'b0;
    last    = 1'b0;
    gap_hit = 1'b0;
    abort   = 1'b0;
    crc_d   = crc_step(crc_q, bit_in);
    start   = bit_valid & sof;
    if (state_q == RECV) begin
      take    = bit_valid & ~sof;
      last    = take & (cnt_q == 6'd39);
      gap_hit = ~bit_valid & (GAP_MAX != 0) & ((gap_q + GW'(1)) == GAP_LIM);
      abort   = start | gap_hit;
    end
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      crc_q   <= '0;
      shreg_q <= '0;
      gap_q   <= '0;
    end else if (start) begin
      cnt_q   <= 6'd1;
      crc_q   <= crc_step(16'h0000, bit_in);
      shreg_q <= {shreg_q[22:0], bit_in};
      gap_q   <= '0;
    end else if (take) begin
      crc_q <= crc_d;
      if (cnt_q < 6'd24) shreg_q <= {shreg_q[22:0], bit_in};
      cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
      gap_q <= '0;
    end else if (state_q == RECV) begin
      gap_q <= gap_hit ? '0 : gap_q + GW'(1);
      if (gap_hit) cnt_q <= '0;
    end
  end

  // Output register: a completing frame may load in the same edge as a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      payload_out <= '0;
      crc_ok      <= 1'b0;
      err_abort   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_abort   <= abort;
      err_overrun <= last & out_valid & ~out_ready;
      if (last && (!out_valid || out_ready)) begin
        out_valid   <= 1'b1;
        payload_out <= shreg_q;
        crc_ok      <= (crc_d == 16'h0000);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_rx.sv
// Self-checking bench for crc_frame_rx: vector table of frames plus hand-written
// sequences for backpressure, mid-frame sof, gap timeout and async reset.
module tb_crc_frame_rx;

  localparam int GAP = 4;

  logic        clk;
  logic        rst_n;
  logic        bit_valid;
  logic        bit_in;
  logic        sof;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] payload_out;
  logic        crc_ok;
  logic        err_abort;
  logic        err_overrun;
  logic        dbg_state;

  crc_frame_rx #(.GAP_MAX(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .out_valid(out_valid), .out_ready(out_ready), .payload_out(payload_out),
    .crc_ok(crc_ok), .err_abort(err_abort), .err_overrun(err_overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;
  int overrun_cnt = 0;
  int valid_cycles = 0;
  logic [24:0] exp_q[$];

  typedef struct {
    logic [23:0] payload;
    logic [15:0] crc;
    logic        exp_ok;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_crc(input logic [23:0] p);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    for (int i = 23; i >= 0; i--) begin
      fb = p[i] ^ c[15];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic drive_bit(input logic b, input logic s);
    bit_valid = 1'b1;
    bit_in    = b;
    sof       = s;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    sof       = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [23:0] p, input logic [15:0] c, input int nbits,
                            input int gap_after, input int gap_len, input bit rdy_last);
    logic [39:0] f;
    f = {p, c};
    for (int i = 0; i < nbits; i++) begin
      if (rdy_last && i == 39) out_ready = 1'b1;
      drive_bit(f[39-i], i == 0);
      if (i == gap_after) idle(gap_len);
    end
  endtask

  task automatic send_good(input logic [23:0] p, input bit push);
    if (push) exp_q.push_back({p, 1'b1});
    send_frame(p, model_crc(p), 40, -1, 0, 1'b0);
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [24:0] e;
    if (rst_n) begin
      if (err_abort)   abort_cnt++;
      if (err_overrun) overrun_cnt++;
      if (out_valid)   valid_cycles++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got payload %h, expected no frame", payload_out);
        end else begin
          e = exp_q.pop_front();
          check("sb_payload", {8'h0, payload_out}, {8'h0, e[24:1]});
          check("sb_crc_ok", {31'h0, crc_ok}, {31'h0, e[0]});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, ab0, ov0;
    logic [23:0] pa, pb, pc;

    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sof = 1'b0; out_ready = 1'b1;
    vecs[0] = '{24'h000001, 16'h1021, 1'b1};
    vecs[1] = '{24'h000100, 16'h3330, 1'b0};
    vecs[2] = '{24'h000100, 16'h3331, 1'b1};
    for (int i = 3; i < 10; i++) begin
      vecs[i].payload = 24'($urandom());
      vecs[i].crc     = model_crc(vecs[i].payload);
      vecs[i].exp_ok  = 1'b1;
      if (i % 2 == 1) begin
        vecs[i].crc    = vecs[i].crc ^ (16'h0001 << $urandom_range(0, 15));
        vecs[i].exp_ok = 1'b0;
      end
    end

    idle(2);
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_payload", {8'h0, payload_out}, 0);
    check("rst_crc_ok", {31'h0, crc_ok}, 0);
    check("rst_err_abort", {31'h0, err_abort}, 0);
    check("rst_err_overrun", {31'h0, err_overrun}, 0);
    check("rst_state", {31'h0, dbg_state}, 0);
    rst_n = 1'b1;
    idle(1);

    // single good frame: out_valid high exactly one cycle
    exp_q.push_back({24'h000001, 1'b1});
    v0 = valid_cycles;
    send_frame(24'h000001, 16'h1021, 40, -1, 0, 1'b0);
    idle(4);
    check("t1_valid_cycles", valid_cycles - v0, 1);

    // vector table, frames back-to-back
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].payload, vecs[i].exp_ok});
      send_frame(vecs[i].payload, vecs[i].crc, 40, -1, 0, 1'b0);
    end
    idle(4);
    check("table_no_abort", abort_cnt, 0);
    check("table_no_overrun", overrun_cnt, 0);

    // backpressure: second frame dropped, third loads as the first transfers
    pa = 24'($urandom()); pb = 24'($urandom()); pc = 24'($urandom());
    out_ready = 1'b0;
    ov0 = overrun_cnt;
    send_good(pa, 1'b1);
    send_good(pb, 1'b0);
    idle(2);
    check("ovr_pulse", overrun_cnt - ov0, 1);
    check("ovr_held_valid", {31'h0, out_valid}, 1);
    check("ovr_held_payload", {8'h0, payload_out}, {8'h0, pa});
    check("ovr_held_crc_ok", {31'h0, crc_ok}, 1);
    exp_q.push_back({pc, 1'b1});
    send_frame(pc, model_crc(pc), 40, -1, 0, 1'b1);
    idle(3);
    check("ovr_no_second_pulse", overrun_cnt - ov0, 1);

    // sof at bit 17 restarts the frame
    ab0 = abort_cnt;
    send_frame(24'($urandom()), 16'h0, 17, -1, 0, 1'b0);
    send_good(24'($urandom()), 1'b1);
    idle(3);
    check("midsof_abort", abort_cnt - ab0, 1);

    // gap of GAP-1 idle cycles is tolerated
    ab0 = abort_cnt;
    pa = 24'($urandom());
    exp_q.push_back({pa, 1'b1});
    send_frame(pa, model_crc(pa), 40, 9, GAP - 1, 1'b0);
    idle(3);
    check("gap_tolerated", abort_cnt - ab0, 0);

    // gap of GAP idle cycles aborts after bit 10
    send_frame(24'($urandom()), 16'h0, 11, -1, 0, 1'b0);
    idle(GAP);
    check("gap_state_idle", {31'h0, dbg_state}, 0);
    idle(2);
    check("gap_abort", abort_cnt - ab0, 1);
    for (int i = 0; i < 10; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    check("nosof_state_idle", {31'h0, dbg_state}, 0);
    check("nosof_no_output", {31'h0, out_valid}, 0);
    send_good(24'($urandom()), 1'b1);
    idle(3);

    // async reset at bit 30 with a frame held
    out_ready = 1'b0;
    send_good(24'hA5A5A5, 1'b0);
    send_frame(24'($urandom()), 16'h0, 30, -1, 0, 1'b0);
    check("prerst_held", {31'h0, out_valid}, 1);
    ab0 = abort_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 0);
    check("arst_payload", {8'h0, payload_out}, 0);
    check("arst_crc_ok", {31'h0, crc_ok}, 0);
    check("arst_state", {31'h0, dbg_state}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send_good(24'($urandom()), 1'b1);
    idle(3);
    check("arst_no_abort", abort_cnt - ab0, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_rx.md
# crc_frame_rx

Bit-serial frame receiver and CRC checker that sits directly upstream of the payload consumer and alongside the CRC-16-CCITT 24-bit package function. It assembles a 40-bit frame (24-bit payload, MSB first, then 16-bit CRC, MSB first) and runs the CRC serially over all 40 bits. It presents the payload with a pass/fail flag on a valid/ready output register. Frames that are aborted, stalled or overrun are reported by one-cycle pulses.

## Interface
- `GAP_MAX`, default 64: maximum idle cycles allowed between accepted bits inside a frame. 0 disables the gap timeout.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `bit_valid` input 1: `bit_in` is valid this cycle.
- `bit_in` input 1: serial data bit.
- `sof` input 1: start of frame; only meaningful while `bit_valid` is high, and marks that bit as frame bit 0 (payload[23]).
- `out_valid` output 1: the output register holds a completed frame.
- `out_ready` input 1: consumer accepts; a transfer happens when `out_valid` and `out_ready` are both high at a rising edge.
- `payload_out` output 24: payload of the held frame.
- `crc_ok` output 1: CRC check result for the held frame.
- `err_abort` output 1: one-cycle pulse when a partial frame is discarded.
- `err_overrun` output 1: one-cycle pulse when a completed frame is dropped.

## Operation
- States are IDLE and RECV, plus a 6-bit bit counter `cnt`, a 16-bit `crc` register, a 24-bit shift register and a gap counter.
- CRC step, per accepted bit b: `fb = b ^ crc[15]`, then `crc = {crc[14:0],0} ^ (fb ? 16'h1021 : 0)`. The step is applied to all 40 bits, including the received CRC bits. With init=0 and xorout=0, a valid frame leaves a residue of 16'h0000, so `crc_ok = (residue == 0)`.
- IDLE:
  - `bit_valid & sof` → RECV, `cnt=1`, `crc` = step(0, bit), payload shift gets the bit.
  - `bit_valid` without `sof` is ignored.
- RECV, on `bit_valid & !sof`:
  - Shift the bit, step the CRC, `cnt++`, clear the gap counter.
  - Bits 0–23 shift into the payload register; bits 24–39 only update the CRC.
  - On bit 39 (`cnt==39`) the frame completes → IDLE.
- RECV with `bit_valid & sof`: pulse `err_abort`, then restart as frame bit 0 and stay in RECV.
- RECV without `bit_valid`: the gap counter increments. When `GAP_MAX != 0` and the counter reaches `GAP_MAX`, pulse `err_abort` and go to IDLE.
- On completion:
  - If `!out_valid`, or `out_ready` is high at the same edge, load `payload_out` and `crc_ok` and set `out_valid`.
  - Otherwise drop the frame, pulse `err_overrun`, and leave the held frame unchanged.
- A transfer with no completion at the same edge clears `out_valid`. `payload_out` and `crc_ok` hold their last values.
- The receive path never stalls on output backpressure.

## Timing
- Reset (async assert) forces: IDLE, `cnt=0`, `crc=0`, gap counter 0, `out_valid=0`, `payload_out=0`, `crc_ok=0`, `err_abort=0`, `err_overrun=0`.
- Reset deassertion mid-frame yields a clean IDLE; the partial frame is lost with no pulse.
- Latency: `out_valid`, `payload_out` and `crc_ok` are updated at the rising edge that samples bit 39, so they are visible in the following cycle.
- Error pulses are registered: high for exactly one cycle after the triggering edge.
- Back-to-back frames are legal: `sof` on the cycle after bit 39 starts the next frame with no gap.
- Outputs `payload_out` and `crc_ok` are stable while `out_valid` is high and no transfer has occurred.
- Gap timeout: abort happens on the edge where the count of consecutive non-valid cycles in RECV reaches `GAP_MAX`. With `GAP_MAX=64`, 63 idle cycles are tolerated.

## Test plan
- Good frame: payload 24'h000001, CRC 16'h1021, bits sent contiguously, `out_ready=1` → `out_valid` high 1 cycle, `payload_out=24'h000001`, `crc_ok=1`.
- Bad CRC: payload 24'h000100 with CRC 16'h3330 instead of the correct 16'h3331 → `payload_out=24'h000100`, `crc_ok=0`; repeat with 16'h3331 → `crc_ok=1`.
- Backpressure and overrun:
  - Two good frames back-to-back with `out_ready=0` → the first frame is held, `err_overrun` pulses at the second frame's completion, `payload_out` stays the first frame.
  - Then raise `out_ready` on the cycle a third frame's bit 39 is sampled → the third frame loads with no overrun.
- Mid-frame `sof`: assert `sof` at bit 17, then send a full good frame → `err_abort` pulses once and a correct frame is output.
- Gap timeout: `GAP_MAX=4`, stop after bit 10 for 4 cycles → `err_abort` pulses and state returns to IDLE. Bits without `sof` are then ignored; a following good frame decodes with `crc_ok=1`.
- Reset mid-frame at bit 30 → all outputs 0 immediately (async). The next good frame decodes correctly.
